nibble_add_seq: RTL and testbench

NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

---
 rtl/nibble_add_seq.sv | 178 +++++++++++++++++
 tb/tb_nibble_add_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_add_seq.sv
// ============================================================================
//  Module   : nibble_add_seq
//  Purpose  : Sequential W-bit adder (W = 4*NIBBLES). It drives an external
//             4-bit ripple adder with one nibble per clock and collects the
//             returned nibble sums into a registered result.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NIBBLES   number of 4-bit digits per operand (default 4)
//  Ports
//    clk         rising-edge clock
//    rst_n       asynchronous active-low reset
//    start_i     request an addition (sampled only in IDLE)
//    op_a_i      operand A, captured when start is accepted
//    op_b_i      operand B, captured when start is accepted
//    cin_i       initial carry-in, captured when start is accepted
//    add_a_o     nibble operand A to the external adder (0 outside RUN)
//    add_b_o     nibble operand B to the external adder (0 outside RUN)
//    add_c_o     carry-in to the external adder (0 outside RUN)
//    add_s_i     nibble sum from the external adder (combinational)
//    add_co_i    carry-out from the external adder
//    sum_o       registered W-bit result (modulo 2^W)
//    cout_o      registered carry-out of the top nibble
//    busy_o      high while nibbles are being processed
//    done_o      one-cycle pulse when sum_o/cout_o are valid
//    ovf_o       signed overflow flag (only with OVERFLOW_FLAG_EN)
//  Configuration macro
//    OVERFLOW_FLAG_EN  adds the registered signed-overflow output ovf_o
// ============================================================================
`default_nettype none

module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [4*NIBBLES-1:0]   op_a_i,
    input  logic [4*NIBBLES-1:0]   op_b_i,
    input  logic                   cin_i,
    output logic [3:0]             add_a_o,
    output logic [3:0]             add_b_o,
    output logic                   add_c_o,
    input  logic [3:0]             add_s_i,
    input  logic                   add_co_i,
    output logic [4*NIBBLES-1:0]   sum_o,
    output logic                   cout_o,
    output logic                   busy_o,
    output logic                   done_o
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic                   ovf_o
`endif
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic              carry_q;
    logic [IDXW-1:0]   idx_q;
    logic [W-1:0]      sum_q;
    logic              cout_q;
    logic              busy_q;
    logic              done_q;
`ifdef OVERFLOW_FLAG_EN
    logic              ovf_q;
`endif

    logic [3:0]        nib_a;
    logic [3:0]        nib_b;
    logic [W-1:0]      sum_d;
    logic              in_run;
    logic              last_nib;

    assign in_run   = (state_q == S_RUN);
    assign last_nib = (idx_q == LAST_IDX);

    // Select the current nibble of each latched operand and build the next
    // result by replacing only the nibble slot addressed by idx_q.
    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        sum_d = sum_q;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IDXW'(n)) begin
                nib_a             = a_q[4*n +: 4];
                nib_b             = b_q[4*n +: 4];
                sum_d[4*n +: 4]   = add_s_i;
            end
        end
    end

    // The external adder sees quiet zeros whenever no nibble is in flight.
    assign add_a_o = in_run ? nib_a : 4'h0;
    assign add_b_o = in_run ? nib_b : 4'h0;
    assign add_c_o = in_run & carry_q;

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
`ifdef OVERFLOW_FLAG_EN
    assign ovf_o  = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_q     <= op_a_i;
                        b_q     <= op_b_i;
                        carry_q <= cin_i;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= add_co_i;
                    if (last_nib) begin
                        // Top nibble: the carry leaves through cout only,
                        // idx wraps so non-power-of-two NIBBLES stays legal.
                        cout_q  <= add_co_i;
`ifdef OVERFLOW_FLAG_EN
                        // Signed overflow: like-signed operands whose result
                        // sign differs; add_s_i[3] is the result MSB here.
                        ovf_q   <= (a_q[W-1] == b_q[W-1]) &&
                                   (add_s_i[3] != a_q[W-1]);
`endif
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= idx_q + IDXW'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nibble_add_seq.sv
// ============================================================================
//  Module   : tb_nibble_add_seq
//  Purpose  : Self-checking bench for nibble_add_seq (NIBBLES = 4). Models
//             the external 4-bit ripple adder and applies directed vectors
//             with hand-computed results, plus restart and reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_add_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cin;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_c;
    logic [3:0]  add_s;
    logic        add_co;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
    logic        done;
`ifdef OVERFLOW_FLAG_EN
    logic        ovf;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // External 4-bit ripple adder.
    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_c};

    nibble_add_seq #(.NIBBLES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .cin_i    (cin),
        .add_a_o  (add_a),
        .add_b_o  (add_b),
        .add_c_o  (add_c),
        .add_s_i  (add_s),
        .add_co_i (add_co),
        .sum_o    (sum),
        .cout_o   (cout),
        .busy_o   (busy),
        .done_o   (done)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf_o    (ovf)
`endif
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic [3:0]  carries;   // expected add_c for nibbles 3..0
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Called at a falling edge: drives a request so it is accepted at the
    // next rising edge (edge k). Sample j is taken just after edge k+j.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic c, input int restart_at, input int rst_at,
                          output logic [7:0] busy_m, output logic [7:0] done_m,
                          output logic [3:0] carry_m, output logic [15:0] sum_f,
                          output logic co_f, output logic ov_f,
                          output logic idle_ok);
        op_a    = a;
        op_b    = b;
        cin     = c;
        start   = 1'b1;
        busy_m  = '0;
        done_m  = '0;
        carry_m = '0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            busy_m[j] = busy;
            done_m[j] = done;
            if (j < 4) carry_m[j] = add_c;
            if (j == 0) start = 1'b0;
            if (restart_at >= 0 && j == restart_at) begin
                start = 1'b1;
                op_a  = 16'hFFFF;
                op_b  = 16'hFFFF;
            end
            if (restart_at >= 0 && j == restart_at + 1) start = 1'b0;
            if (rst_at >= 0 && j == rst_at) rst_n = 1'b0;
            if (rst_at >= 0 && j == rst_at + 2) rst_n = 1'b1;
        end
        sum_f   = sum;
        co_f    = cout;
`ifdef OVERFLOW_FLAG_EN
        ov_f    = ovf;
`else
        ov_f    = 1'b0;
`endif
        idle_ok = (add_a == 4'h0) && (add_b == 4'h0) && !add_c && !busy && !done;
    endtask

    vec_t        vecs[7];
    logic [7:0]  bm, dm;
    logic [3:0]  cm;
    logic [15:0] sf;
    logic        cf, of, iok;

    initial begin
        vecs[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 4'b0000};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110};
        vecs[2] = '{16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b1111};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 4'b0001};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000};
        vecs[6] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 4'b0000};

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = 16'h0;
        op_b  = 16'h0;
        cin   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_sum",  {16'h0, sum}, 32'h0);
        check("rst_cout", {31'h0, cout}, 32'h0);
        check("rst_busy_done", {30'h0, busy, done}, 32'h0);
        check("rst_add_out", {23'h0, add_a, add_b, add_c}, 32'h0);
`ifdef OVERFLOW_FLAG_EN
        check("rst_ovf", {31'h0, ovf}, 32'h0);
`endif

        // Release reset and request immediately: accepted at first edge.
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c, -1, -1,
                   bm, dm, cm, sf, cf, of, iok);
            check($sformatf("v%0d_sum", i),   {16'h0, sf}, {16'h0, vecs[i].s});
            check($sformatf("v%0d_cout", i),  {31'h0, cf}, {31'h0, vecs[i].co});
            check($sformatf("v%0d_busy", i),  {24'h0, bm}, 32'h0F);
            check($sformatf("v%0d_done", i),  {24'h0, dm}, 32'h10);
            check($sformatf("v%0d_addc", i),  {28'h0, cm}, {28'h0, vecs[i].carries});
            check($sformatf("v%0d_idle", i),  {31'h0, iok}, 32'h1);
`ifdef OVERFLOW_FLAG_EN
            check($sformatf("v%0d_ovf", i),   {31'h0, of}, {31'h0, vecs[i].ov});
`endif
        end

        // Second start during RUN (sampled at edge k+2) must be ignored.
        run_op(16'h1234, 16'h1111, 1'b0, 1, -1, bm, dm, cm, sf, cf, of, iok);
        check("restart_sum",  {16'h0, sf}, 32'h2345);
        check("restart_cout", {31'h0, cf}, 32'h0);
        check("restart_busy", {24'h0, bm}, 32'h0F);
        check("restart_done", {24'h0, dm}, 32'h10);

        // Reset low at edge k+2: abort, no done, result cleared.
        run_op(16'h5555, 16'hAAAA, 1'b1, -1, 1, bm, dm, cm, sf, cf, of, iok);
        check("abort_sum",  {16'h0, sf}, 32'h0);
        check("abort_cout", {31'h0, cf}, 32'h0);
        check("abort_busy", {24'h0, bm}, 32'h03);
        check("abort_done", {24'h0, dm}, 32'h00);
        check("abort_idle", {31'h0, iok}, 32'h1);

        run_op(16'h000F, 16'h0001, 1'b0, -1, -1, bm, dm, cm, sf, cf, of, iok);
        check("post_sum",  {16'h0, sf}, 32'h0010);
        check("post_cout", {31'h0, cf}, 32'h0);
        check("post_done", {24'h0, dm}, 32'h10);
        check("post_addc", {28'h0, cm}, 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
